// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle req/ack clock-domain crossing (tx and rx ends).
package cdc_pkg;

  // FSM encoding shared with the matching receive block.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int unsigned CDC_SYNC_STAGES = 2;

endpackage

// File: rtl/ff_sync.sv
// Multi-stage flop synchronizer for a level (or toggle) crossing into the clk domain.
module ff_sync
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = CDC_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

  // Shift the asynchronous input down the chain one stage per clock.
  always_comb begin
    sync_d[0] = data_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer stage registers.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain end of a 2-edge toggle req/ack crossing: holds a word and toggles req,
// then waits for the synchronized ack level to match before accepting the next word.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack_async,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xfer_data_q, xfer_data_d;
  logic             xfer_req_q, xfer_req_d;
  logic             done_q, done_d;
  logic             ack_s;
  logic             accept;
  logic             wait_pend;

  ff_sync #(
    .WIDTH (1),
    .STAGES(CDC_SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_p (rst_p),
    .data_i(xfer_ack_async),
    .data_o(ack_s)
  );

  // Next-state, payload capture and handshake outputs.
  always_comb begin
    state_d     = state_q;
    xfer_data_d = xfer_data_q;
    xfer_req_d  = xfer_req_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    wait_pend   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        // An ack level change seen here is a receiver protocol error and is ignored.
        if (in_valid) begin
          accept      = 1'b1;
          xfer_data_d = in_data;
          xfer_req_d  = ~xfer_req_q;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (ack_s == xfer_req_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_pend = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, payload and req registers.
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q     <= S_IDLE;
      xfer_data_q <= '0;
      xfer_req_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xfer_data_q <= xfer_data_d;
      xfer_req_q  <= xfer_req_d;
      done_q      <= done_d;
    end
  end

  assign xfer_data = xfer_data_q;
  assign xfer_req  = xfer_req_q;
  assign done      = done_q;

  if (TIMEOUT != 0) begin : g_timeout
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             hit;

    // Saturating wait counter; err is sticky and never aborts the transfer.
    always_comb begin
      cnt_d = cnt_q;
      hit   = 1'b0;
      if (accept) begin
        cnt_d = '0;
      end else if (wait_pend) begin
        hit = (cnt_q == CNT_W'(TIMEOUT - 1));
        if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      err_d = err_q;
      if (err_clr) err_d = 1'b0;
      // A coincident timeout hit wins over the clear.
      if (hit) err_d = 1'b1;
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign err = err_q;
  end else begin : g_no_timeout
    logic unused_timeout;
    assign unused_timeout = ^{accept, wait_pend, err_clr};
    assign err            = 1'b0;
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed + randomized bench for cdc_hs_tx with a behavioural far-domain receiver model.
module tb_cdc_hs_tx;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst_p;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] xfer_data;
  logic         xfer_req;
  logic         ack;
  logic         busy;
  logic         done;
  logic         err;
  logic         err_clr;

  int unsigned  n_pass = 0;
  int unsigned  n_chk  = 0;
  bit           model_req;
  bit           err_m;
  logic [W-1:0] last_word;

  always #5 clk = ~clk;

  cdc_hs_tx #(
    .WIDTH  (W),
    .TIMEOUT(TO),
    .CNT_W  (16)
  ) dut (
    .clk           (clk),
    .rst_p         (rst_p),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .xfer_data     (xfer_data),
    .xfer_req      (xfer_req),
    .xfer_ack_async(ack),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .err_clr       (err_clr)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer: receiver echoes req d edges after accept, so ack_s matches at edge d+2
  // and done is visible after edge d+3. Timeout fires at the 8th unanswered WAIT edge,
  // i.e. only when d+2 >= 8. clr_at (0 = none) pulses err_clr before that edge.
  task automatic xfer(input logic [W-1:0] word, input int d, input bit keep_valid,
                      input int clr_at);
    in_valid = 1'b1;
    in_data  = word;
    tick();
    model_req = ~model_req;
    last_word = word;
    chk("acc_data", xfer_data, word);
    chk("acc_req", xfer_req, model_req);
    chk("acc_busy", busy, 1);
    chk("acc_ready", in_ready, 0);
    chk("acc_done", done, 0);
    chk("acc_err", err, err_m);
    if (!keep_valid) in_valid = 1'b0;
    in_data = $urandom;
    for (int k = 1; k <= d + 3; k++) begin
      err_clr = (k == clr_at);
      tick();
      err_clr = 1'b0;
      if (d >= 6 && k == 8) err_m = 1'b1;
      else if (k == clr_at) err_m = 1'b0;
      if (k == d) ack = model_req;
      chk("w_busy", busy, (k < d + 3));
      chk("w_done", done, (k == d + 3));
      chk("w_ready", in_ready, (k == d + 3));
      chk("w_data", xfer_data, word);
      chk("w_req", xfer_req, model_req);
      chk("w_err", err, err_m);
      in_data = $urandom;
    end
  endtask

  initial begin
    rst_p     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    ack       = 1'b0;
    err_clr   = 1'b0;
    model_req = 1'b0;
    err_m     = 1'b0;
    last_word = '0;

    // Reset: in_valid held high must not be accepted.
    repeat (3) tick();
    chk("rst_data", xfer_data, 0);
    chk("rst_req", xfer_req, 0);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0;
    rst_p    = 1'b0;
    tick();
    chk("rel_ready", in_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_done", done, 0);
    chk("rel_err", err, 0);
    chk("rel_data", xfer_data, 0);

    // 1: single word, ack 5 cycles after accept.
    xfer(32'hDEAD_BEEF, 5, 1'b0, 0);

    // 2: four words with in_valid held high; each accept lands in the done cycle.
    for (int i = 1; i <= 4; i++) xfer(W'(i), 1 + (i % 3), 1'b1, 0);
    in_valid = 1'b0;
    tick();
    chk("t2_done_once", done, 0);
    chk("t2_idle", busy, 0);

    // 3: no ack for a long time -> err, transfer still completes, then clear.
    xfer(32'h1357_9BDF, 12, 1'b0, 0);
    chk("t3_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("t3_err_clr", err, 0);

    // 4: clear coinciding with the timeout hit -> set wins; a later clear then works.
    xfer(32'h0F0F_0F0F, 10, 1'b0, 8);
    chk("t4_set_wins", err, 1);
    xfer(32'hF0F0_F0F0, 10, 1'b0, 9);
    chk("t4_clr_after", err, 0);

    // 5: asynchronous reset mid-WAIT with req=1.
    if (model_req) xfer(32'h2222_2222, 2, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    tick();
    model_req = 1'b1;
    in_valid  = 1'b0;
    chk("t5_req_hi", xfer_req, 1);
    tick();
    #2;
    rst_p = 1'b1;
    #1;
    chk("t5_req", xfer_req, 0);
    chk("t5_data", xfer_data, 0);
    chk("t5_busy", busy, 0);
    ack       = 1'b0;
    model_req = 1'b0;
    err_m     = 1'b0;
    last_word = '0;
    #3;
    rst_p = 1'b0;
    tick();
    chk("t5_ready", in_ready, 1);
    xfer(32'h0BAD_CAFE, 3, 1'b0, 0);

    // 6: spurious ack toggle and in_data wiggle while idle.
    ack = ~ack;
    for (int i = 0; i < 6; i++) begin
      in_data = $urandom;
      tick();
      chk("t6_done", done, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready", in_ready, 1);
      chk("t6_req", xfer_req, model_req);
      chk("t6_data", xfer_data, last_word);
    end
    ack = model_req;
    repeat (3) tick();

    // Randomized transfers against the receiver/timeout model.
    for (int n = 0; n < 20; n++) begin
      int d;
      d = int'($urandom_range(1, 10));
      xfer($urandom, d, 1'($urandom_range(0, 1)), int'($urandom_range(0, d + 3)));
    end
    in_valid = 1'b0;
    tick();
    chk("end_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
